// File: rtl/reg_write_sched.sv
// reg_write_sched: write-port scheduler in front of the 16-entry register file.
// Arbitrates ALU results and load returns onto one registered write port.
// It tracks one outstanding load destination and flags decode read hazards.
// Optional feature: define LD_TIMEOUT_EN to abort a load that waits TIMEOUT cycles.
module reg_write_sched #(
    parameter int unsigned W       = 8,
    parameter int unsigned A       = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Alu_Valid,
    input  logic [A-1:0] Alu_Addr,
    input  logic [W-1:0] Alu_Data,
    output logic         Alu_Ready,
    input  logic         Ld_Issue,
    input  logic [A-1:0] Ld_Addr,
    output logic         Ld_Ready,
    input  logic         Mem_Valid,
    input  logic [W-1:0] Mem_Data,
    input  logic [A-1:0] Chk_AddrA,
    input  logic [A-1:0] Chk_AddrB,
    output logic         Hazard,
    output logic         WriteEn,
    output logic [A-1:0] Waddr,
    output logic [W-1:0] WData,
    output logic         Ld_Err
);

    typedef enum logic {IDLE = 1'b0, LD_WAIT = 1'b1} state_t;

    state_t       state_q, state_d;
    logic [A-1:0] pend_dest_q, pend_dest_d;
    logic         squash_q, squash_d;
    logic         skid_full_q, skid_full_d;
    logic [A-1:0] skid_addr_q, skid_addr_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         we_q, we_d;
    logic [A-1:0] waddr_q, waddr_d;
    logic [W-1:0] wdata_q, wdata_d;

    logic         alu_acc;
    logic         mem_win;
    logic         waw;

`ifdef LD_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ld_err_q, ld_err_d;
    logic          timeout;
`else
    logic          unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    assign Alu_Ready = !skid_full_q;
    assign Ld_Ready  = (state_q == IDLE);
    assign Hazard    = (state_q == LD_WAIT) &&
                       ((Chk_AddrA == pend_dest_q) || (Chk_AddrB == pend_dest_q));
    assign WriteEn   = we_q;
    assign Waddr     = waddr_q;
    assign WData     = wdata_q;

    assign alu_acc = Alu_Valid && !skid_full_q;
    assign mem_win = (state_q == LD_WAIT) && Mem_Valid && !squash_q;
    // A younger ALU write to the pending destination makes the load data stale.
    assign waw     = (state_q == LD_WAIT) && alu_acc && (Alu_Addr == pend_dest_q);

`ifdef LD_TIMEOUT_EN
    // Counter reaches TIMEOUT on the same edge that leaves LD_WAIT, so the check
    // is one below; a return in that cycle takes precedence.
    assign timeout = (state_q == LD_WAIT) && !Mem_Valid && (cnt_q == CW'(TIMEOUT - 1));
    assign Ld_Err  = ld_err_q;
`else
    assign Ld_Err  = 1'b0;
`endif

    // Next-state: load FSM, squash tracking, skid buffer and write-port arbitration.
    always_comb begin
        state_d     = state_q;
        pend_dest_d = pend_dest_q;
        squash_d    = squash_q;
        skid_full_d = skid_full_q;
        skid_addr_d = skid_addr_q;
        skid_data_d = skid_data_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
`ifdef LD_TIMEOUT_EN
        cnt_d       = cnt_q;
        ld_err_d    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (Ld_Issue) begin
                    state_d     = LD_WAIT;
                    pend_dest_d = Ld_Addr;
                    squash_d    = 1'b0;
`ifdef LD_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            LD_WAIT: begin
                if (Mem_Valid) begin
                    state_d = IDLE;
                end
`ifdef LD_TIMEOUT_EN
                else if (timeout) begin
                    state_d  = IDLE;
                    ld_err_d = 1'b1;
                end
                cnt_d = cnt_q + 1'b1;
`endif
                if (waw) begin
                    squash_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Priority: load return, then skid entry, then new ALU result.
        if (mem_win) begin
            we_d    = 1'b1;
            waddr_d = pend_dest_q;
            wdata_d = Mem_Data;
            if (alu_acc) begin
                skid_full_d = 1'b1;
                skid_addr_d = Alu_Addr;
                skid_data_d = Alu_Data;
            end
        end else if (skid_full_q) begin
            we_d        = 1'b1;
            waddr_d     = skid_addr_q;
            wdata_d     = skid_data_q;
            skid_full_d = 1'b0;
        end else if (alu_acc) begin
            we_d    = 1'b1;
            waddr_d = Alu_Addr;
            wdata_d = Alu_Data;
        end
    end

    // State and registered outputs; synchronous active-high reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            pend_dest_q <= '0;
            squash_q    <= 1'b0;
            skid_full_q <= 1'b0;
            skid_addr_q <= '0;
            skid_data_q <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
`ifdef LD_TIMEOUT_EN
            cnt_q       <= '0;
            ld_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pend_dest_q <= pend_dest_d;
            squash_q    <= squash_d;
            skid_full_q <= skid_full_d;
            skid_addr_q <= skid_addr_d;
            skid_data_q <= skid_data_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
`ifdef LD_TIMEOUT_EN
            cnt_q       <= cnt_d;
            ld_err_q    <= ld_err_d;
`endif
        end
    end

endmodule
